// File: rtl/qos_read_scheduler_if.sv
// qos_read_scheduler_if: pop request/acknowledge handshake and buffer occupancy between scheduler and buffer manager
interface qos_read_scheduler_if;
  logic [7:0] buf_count;
  logic       rd_ack;
  logic [3:0] rd_req;
  modport master (input buf_count, rd_ack, output rd_req);
  modport slave (output buf_count, rd_ack, input rd_req);
endinterface

// File: rtl/qos_read_scheduler.sv
// qos_read_scheduler: weighted-round-robin read tick scheduler for four packet buffers
// Define QOS_ACK_TIMEOUT_EN to abort unacknowledged requests after ACK_TIMEOUT cycles.
module qos_read_scheduler #(
  parameter int READ_PERIOD = 100_000_000,
  parameter int W1 = 1,
  parameter int W2 = 2,
  parameter int W3 = 3,
  parameter int W4 = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  qos_read_scheduler_if.master   bus,
  output logic [3:0]             next_read,
  output logic                   time_to_read,
  output logic [28:0]            counter_read,
  output logic                   round_done,
  output logic                   rd_timeout
);
  function automatic logic [2:0] wt(input int w);
    return (w == 0) ? 3'd1 : 3'(w);
  endfunction
  function automatic logic [3:0] top1(input logic [3:0] v);
    return v[3] ? 4'b1000 : v[2] ? 4'b0100 : v[1] ? 4'b0010 : v[0] ? 4'b0001 : 4'b0000;
  endfunction
  localparam logic [28:0] LAST = 29'(READ_PERIOD - 1);
  localparam logic [11:0] WTS = {wt(W4), wt(W3), wt(W2), wt(W1)};
  typedef enum logic {IDLE, REQ} state_t;
  state_t           state, state_d;
  logic [3:0][2:0]  credit, credit_d;
  logic [3:0]       rd_req, rd_req_d, busy, elig, cand;
  logic             pending, pending_d, reload, round_done_d, rd_timeout_d;
`ifdef QOS_ACK_TIMEOUT_EN
  logic [7:0]       wait_cnt, wait_d;
`endif
  // An exhausted round with data still queued behaves as if credits were already reloaded
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      busy[i] = bus.buf_count[2*i +: 2] != 2'd0;
      elig[i] = busy[i] && credit[i] != 3'd0;
    end
    reload = elig == 4'd0 && busy != 4'd0;
    cand = top1(reload ? busy : elig);
  end
  always_comb begin
    state_d = state;
    rd_req_d = rd_req;
    credit_d = credit;
    pending_d = pending;
    round_done_d = 1'b0;
    rd_timeout_d = 1'b0;
`ifdef QOS_ACK_TIMEOUT_EN
    wait_d = wait_cnt;
`endif
    if (state == IDLE) begin
      if ((time_to_read || pending) && enable && cand != 4'd0) begin
        state_d = REQ;
        rd_req_d = cand;
        pending_d = 1'b0;
        round_done_d = reload;
        credit_d = reload ? WTS : credit;
`ifdef QOS_ACK_TIMEOUT_EN
        wait_d = 8'd0;
`endif
      end else if (cand == 4'd0)
        pending_d = 1'b0;
    end else begin
      pending_d = pending || time_to_read;
      if (bus.rd_ack) begin
        state_d = IDLE;
        rd_req_d = 4'd0;
        for (int i = 0; i < 4; i++)
          credit_d[i] = credit[i] - {2'b0, rd_req[i]};
      end
`ifdef QOS_ACK_TIMEOUT_EN
      else if (wait_cnt == 8'(ACK_TIMEOUT - 1)) begin
        state_d = IDLE;
        rd_req_d = 4'd0;
        rd_timeout_d = 1'b1;
      end else
        wait_d = wait_cnt + 8'd1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_req <= 4'd0;
      credit <= WTS;
      pending <= 1'b0;
      round_done <= 1'b0;
      rd_timeout <= 1'b0;
      next_read <= 4'd0;
      counter_read <= 29'd0;
      time_to_read <= 1'b0;
`ifdef QOS_ACK_TIMEOUT_EN
      wait_cnt <= 8'd0;
`endif
    end else begin
      state <= state_d;
      rd_req <= rd_req_d;
      credit <= credit_d;
      pending <= pending_d;
      round_done <= round_done_d;
      rd_timeout <= rd_timeout_d;
      next_read <= cand;
      counter_read <= enable ? ((counter_read == LAST) ? 29'd0 : counter_read + 29'd1) : counter_read;
      time_to_read <= enable && counter_read == LAST;
`ifdef QOS_ACK_TIMEOUT_EN
      wait_cnt <= wait_d;
`endif
    end
  end
  assign bus.rd_req = rd_req;
endmodule
